// File: rtl/radix4_bfly_twiddle_pipe.sv
// radix4_bfly_twiddle_pipe: 4-stage radix-4 DIT butterfly with twiddle multiply, round/saturate and stall-on-backpressure.
// Define FFT4_SAT_FLAG_EN to add the sticky saturation flag (sat_clr / sat_flag).
module radix4_bfly_twiddle_pipe #(
  parameter int DATA_WIDTH = 21,
  parameter int TWID_WIDTH = 16,
  parameter int LSB_CUTOFF = 12,
  parameter int OUT_WIDTH  = 27,
  parameter int TAG_WIDTH  = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         inv,
  input  logic [TAG_WIDTH-1:0]         tag_in,
  input  logic signed [DATA_WIDTH-1:0] x0_r,
  input  logic signed [DATA_WIDTH-1:0] x1_r,
  input  logic signed [DATA_WIDTH-1:0] x2_r,
  input  logic signed [DATA_WIDTH-1:0] x3_r,
  input  logic signed [DATA_WIDTH-1:0] x0_i,
  input  logic signed [DATA_WIDTH-1:0] x1_i,
  input  logic signed [DATA_WIDTH-1:0] x2_i,
  input  logic signed [DATA_WIDTH-1:0] x3_i,
  input  logic signed [TWID_WIDTH-1:0] w1_r,
  input  logic signed [TWID_WIDTH-1:0] w2_r,
  input  logic signed [TWID_WIDTH-1:0] w3_r,
  input  logic signed [TWID_WIDTH-1:0] w1_i,
  input  logic signed [TWID_WIDTH-1:0] w2_i,
  input  logic signed [TWID_WIDTH-1:0] w3_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  y0_r,
  output logic signed [OUT_WIDTH-1:0]  y1_r,
  output logic signed [OUT_WIDTH-1:0]  y2_r,
  output logic signed [OUT_WIDTH-1:0]  y3_r,
  output logic signed [OUT_WIDTH-1:0]  y0_i,
  output logic signed [OUT_WIDTH-1:0]  y1_i,
  output logic signed [OUT_WIDTH-1:0]  y2_i,
  output logic signed [OUT_WIDTH-1:0]  y3_i,
`ifdef FFT4_SAT_FLAG_EN
  input  logic                         sat_clr,
  output logic                         sat_flag,
`endif
  output logic [TAG_WIDTH-1:0]         tag_out
);
  localparam int ACC_W = DATA_WIDTH + TWID_WIDTH + 2;
  localparam int PW    = ACC_W - 1;
  localparam int TW1   = TWID_WIDTH + 1;
  localparam int RW    = ACC_W - LSB_CUTOFF + 1;
  localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  logic stall;
  logic signed [DATA_WIDTH-1:0] xr [4];
  logic signed [DATA_WIDTH-1:0] xi [4];
  logic signed [TWID_WIDTH-1:0] wr [3];
  logic signed [TWID_WIDTH-1:0] wi [3];
  logic s1_v_q, s2_v_q, s3_v_q, s4_v_q, s1_inv_q, s2_inv_q;
  logic [TAG_WIDTH-1:0] s1_tag_q, s2_tag_q, s3_tag_q, s4_tag_q;
  logic signed [DATA_WIDTH-1:0] s1_xr_q [4];
  logic signed [DATA_WIDTH-1:0] s1_xi_q [4];
  logic signed [TWID_WIDTH-1:0] s1_wr_q [3];
  logic signed [TWID_WIDTH-1:0] s1_wi_q [3];
  logic signed [TW1-1:0] wc [3];
  logic signed [PW-1:0] s2_ar_d [4];
  logic signed [PW-1:0] s2_ai_d [4];
  logic signed [PW-1:0] s2_ar_q [4];
  logic signed [PW-1:0] s2_ai_q [4];
  logic signed [ACC_W-1:0] er [4];
  logic signed [ACC_W-1:0] ei [4];
  logic signed [ACC_W-1:0] fy1r, fy1i, fy3r, fy3i;
  logic signed [ACC_W-1:0] s3_d [8];
  logic signed [ACC_W-1:0] s3_q [8];
  logic signed [RW-1:0] rnd [8];
  logic [7:0] hi, lo;
  logic signed [OUT_WIDTH-1:0] s4_d [8];
  logic signed [OUT_WIDTH-1:0] s4_q [8];
  assign xr = '{x0_r, x1_r, x2_r, x3_r};
  assign xi = '{x0_i, x1_i, x2_i, x3_i};
  assign wr = '{w1_r, w2_r, w3_r};
  assign wi = '{w1_i, w2_i, w3_i};
  assign stall     = s4_v_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = s4_v_q;
  assign tag_out   = s4_tag_q;
  // Twiddle imag is widened before negation so -(-2^(TW-1)) stays exact in inverse mode.
  always_comb begin
    s2_ar_d[0] = PW'(s1_xr_q[0]) <<< (TWID_WIDTH - 1);
    s2_ai_d[0] = PW'(s1_xi_q[0]) <<< (TWID_WIDTH - 1);
    for (int k = 0; k < 3; k++) begin
      wc[k] = s1_inv_q ? -TW1'(s1_wi_q[k]) : TW1'(s1_wi_q[k]);
      s2_ar_d[k+1] = PW'(s1_xr_q[k+1]) * PW'(s1_wr_q[k]) - PW'(s1_xi_q[k+1]) * PW'(wc[k]);
      s2_ai_d[k+1] = PW'(s1_xr_q[k+1]) * PW'(wc[k]) + PW'(s1_xi_q[k+1]) * PW'(s1_wr_q[k]);
    end
  end
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      er[n] = ACC_W'(s2_ar_q[n]);
      ei[n] = ACC_W'(s2_ai_q[n]);
    end
    fy1r = er[0] + ei[1] - er[2] - ei[3];
    fy1i = ei[0] - er[1] - ei[2] + er[3];
    fy3r = er[0] - ei[1] - er[2] + ei[3];
    fy3i = ei[0] + er[1] - ei[2] - er[3];
    s3_d[0] = er[0] + er[1] + er[2] + er[3];
    s3_d[4] = ei[0] + ei[1] + ei[2] + ei[3];
    s3_d[2] = er[0] - er[1] + er[2] - er[3];
    s3_d[6] = ei[0] - ei[1] + ei[2] - ei[3];
    s3_d[1] = s2_inv_q ? fy3r : fy1r;
    s3_d[5] = s2_inv_q ? fy3i : fy1i;
    s3_d[3] = s2_inv_q ? fy1r : fy3r;
    s3_d[7] = s2_inv_q ? fy1i : fy3i;
  end
  // Negative values only round up when strictly past the half point, giving half-away-from-zero.
  always_comb begin
    for (int c = 0; c < 8; c++) begin
      rnd[c]  = RW'(s3_q[c] >>> LSB_CUTOFF) + RW'({1'b0, s3_q[c][LSB_CUTOFF-1] & (!s3_q[c][ACC_W-1] | (|s3_q[c][LSB_CUTOFF-2:0]))});
      hi[c]   = rnd[c] > MAXV;
      lo[c]   = rnd[c] < MINV;
      s4_d[c] = hi[c] ? MAXV[OUT_WIDTH-1:0] : lo[c] ? MINV[OUT_WIDTH-1:0] : rnd[c][OUT_WIDTH-1:0];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {s1_v_q, s2_v_q, s3_v_q, s4_v_q, s1_inv_q, s2_inv_q} <= '0;
      {s1_tag_q, s2_tag_q, s3_tag_q, s4_tag_q} <= '0;
      s1_xr_q <= '{default: '0};
      s1_xi_q <= '{default: '0};
      s1_wr_q <= '{default: '0};
      s1_wi_q <= '{default: '0};
      s2_ar_q <= '{default: '0};
      s2_ai_q <= '{default: '0};
      s3_q    <= '{default: '0};
      s4_q    <= '{default: '0};
    end else if (!stall) begin
      s1_v_q   <= in_valid;
      s1_inv_q <= inv;
      s1_tag_q <= tag_in;
      s1_xr_q  <= xr;
      s1_xi_q  <= xi;
      s1_wr_q  <= wr;
      s1_wi_q  <= wi;
      s2_v_q   <= s1_v_q;
      s2_inv_q <= s1_inv_q;
      s2_tag_q <= s1_tag_q;
      s2_ar_q  <= s2_ar_d;
      s2_ai_q  <= s2_ai_d;
      s3_v_q   <= s2_v_q;
      s3_tag_q <= s2_tag_q;
      s3_q     <= s3_d;
      s4_v_q   <= s3_v_q;
      s4_tag_q <= s3_tag_q;
      s4_q     <= s4_d;
    end
  end
  assign y0_r = s4_q[0];
  assign y1_r = s4_q[1];
  assign y2_r = s4_q[2];
  assign y3_r = s4_q[3];
  assign y0_i = s4_q[4];
  assign y1_i = s4_q[5];
  assign y2_i = s4_q[6];
  assign y3_i = s4_q[7];
`ifdef FFT4_SAT_FLAG_EN
  logic sat_d, sat_q;
  always_comb sat_d = (s3_v_q && !stall && (|hi || |lo)) ? 1'b1 : sat_clr ? 1'b0 : sat_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= 1'b0;
    else sat_q <= sat_d;
  end
  assign sat_flag = sat_q;
`endif
endmodule

// File: tb/tb_radix4_bfly_twiddle_pipe.sv
// tb_radix4_bfly_twiddle_pipe: directed and streaming checks of the radix-4 butterfly against a complex-arithmetic model.
module tb_radix4_bfly_twiddle_pipe;
  typedef struct packed {
    logic              inv;
    logic [10:0]       tag;
    logic [3:0][20:0]  xr;
    logic [3:0][20:0]  xi;
    logic [3:0][15:0]  wr;
    logic [3:0][15:0]  wi;
  } beat_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  beat_t cur = '0, b = '0, e_b;
  logic in_ready, out_valid, rdy_s, ov_s;
  logic [10:0] tag_out, tag_s;
  logic signed [26:0] ya [8];
  logic signed [19:0] yb [8];
`ifdef FFT4_SAT_FLAG_EN
  logic sat_clr = 0, sat_a, sat_s;
`endif
  int checks = 0, errors = 0, n_acc = 0, lat = 0, base = 0, stale = 0;
  bit done = 0;
  beat_t q [$];
  int got_tags [$];
  longint ey [8];
  always #5 clk = ~clk;
  radix4_bfly_twiddle_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inv(cur.inv), .tag_in(cur.tag),
    .x0_r(cur.xr[0]), .x1_r(cur.xr[1]), .x2_r(cur.xr[2]), .x3_r(cur.xr[3]),
    .x0_i(cur.xi[0]), .x1_i(cur.xi[1]), .x2_i(cur.xi[2]), .x3_i(cur.xi[3]),
    .w1_r(cur.wr[1]), .w2_r(cur.wr[2]), .w3_r(cur.wr[3]),
    .w1_i(cur.wi[1]), .w2_i(cur.wi[2]), .w3_i(cur.wi[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0_r(ya[0]), .y1_r(ya[1]), .y2_r(ya[2]), .y3_r(ya[3]),
    .y0_i(ya[4]), .y1_i(ya[5]), .y2_i(ya[6]), .y3_i(ya[7]),
`ifdef FFT4_SAT_FLAG_EN
    .sat_clr(sat_clr), .sat_flag(sat_a),
`endif
    .tag_out(tag_out));
  radix4_bfly_twiddle_pipe #(.OUT_WIDTH(20)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .inv(cur.inv), .tag_in(cur.tag),
    .x0_r(cur.xr[0]), .x1_r(cur.xr[1]), .x2_r(cur.xr[2]), .x3_r(cur.xr[3]),
    .x0_i(cur.xi[0]), .x1_i(cur.xi[1]), .x2_i(cur.xi[2]), .x3_i(cur.xi[3]),
    .w1_r(cur.wr[1]), .w2_r(cur.wr[2]), .w3_r(cur.wr[3]),
    .w1_i(cur.wi[1]), .w2_i(cur.wi[2]), .w3_i(cur.wi[3]),
    .out_valid(ov_s), .out_ready(out_ready),
    .y0_r(yb[0]), .y1_r(yb[1]), .y2_r(yb[2]), .y3_r(yb[3]),
    .y0_i(yb[4]), .y1_i(yb[5]), .y2_i(yb[6]), .y3_i(yb[7]),
`ifdef FFT4_SAT_FLAG_EN
    .sat_clr(sat_clr), .sat_flag(sat_s),
`endif
    .tag_out(tag_s));
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic longint rnd(input longint v);
    return v >= 0 ? (v + 2048) / 4096 : -((-v + 2048) / 4096);
  endfunction
  function automatic longint sat(input longint v, input int ow);
    longint m = 64'sd1 <<< (ow - 1);
    return v > m - 1 ? m - 1 : v < -m ? -m : v;
  endfunction
  // Y_k = sum_n a_n * W^(n*k), W = -j forward, +j inverse; rotation done as repeated multiply by j.
  task automatic model(input beat_t bt, input int ow);
    longint ar [4], ai [4], wr, wi, yr, yi, r, i, t;
    int e;
    ar[0] = longint'($signed(bt.xr[0])) * 32768;
    ai[0] = longint'($signed(bt.xi[0])) * 32768;
    for (int n = 1; n < 4; n++) begin
      wr = longint'($signed(bt.wr[n]));
      wi = longint'($signed(bt.wi[n]));
      if (bt.inv) wi = -wi;
      ar[n] = longint'($signed(bt.xr[n])) * wr - longint'($signed(bt.xi[n])) * wi;
      ai[n] = longint'($signed(bt.xr[n])) * wi + longint'($signed(bt.xi[n])) * wr;
    end
    for (int k = 0; k < 4; k++) begin
      yr = 0;
      yi = 0;
      for (int n = 0; n < 4; n++) begin
        r = ar[n];
        i = ai[n];
        e = ((bt.inv ? 1 : 3) * n * k) % 4;
        repeat (e) begin
          t = r;
          r = -i;
          i = t;
        end
        yr += r;
        yi += i;
      end
      ey[k]     = sat(rnd(yr), ow);
      ey[4 + k] = sat(rnd(yi), ow);
    end
  endtask
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (in_valid && in_ready) begin
        q.push_back(cur);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("out_valid_unexpected", out_valid, 0);
        else begin
          e_b = q.pop_front();
          got_tags.push_back(int'(tag_out));
          chk("tag", tag_out, e_b.tag);
          chk("tag_s", tag_s, e_b.tag);
          chk("ov_s", ov_s, out_valid);
          chk("rdy_s", rdy_s, in_ready);
          model(e_b, 27);
          for (int c = 0; c < 8; c++) chk($sformatf("y%0d_%s", c % 4, c < 4 ? "r" : "i"), ya[c], ey[c]);
          model(e_b, 20);
          for (int c = 0; c < 8; c++) chk($sformatf("ow20_y%0d_%s", c % 4, c < 4 ? "r" : "i"), yb[c], ey[c]);
        end
      end
    end
  end
  task automatic send(input beat_t bt);
    int n = 0;
    bit acc = 0;
    cur = bt;
    in_valid = 1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_in_ready", in_ready, 1);
    in_valid = 0;
  endtask
  task automatic wait_out();
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("wait_out_valid", out_valid, 1);
  endtask
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end
  initial begin
    int rx [5] = '{1, -1, -2049, -2047, 3};
    int rw [5] = '{2048, 2048, 1, 1, 2048};
    int r0 [5] = '{1, -1, -1, 0, 2};
    int r2 [5] = '{-1, 1, 1, 0, -2};
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y0_r", ya[0], 0);
    chk("rst_tag_out", tag_out, 0);
    sync();
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    sync();
    b = '0;
    b.xr[0] = 21'd100;
    b.tag = 11'd77;
    for (int k = 1; k < 4; k++) begin
      b.wr[k] = 16'd32767;
      b.wi[k] = 16'd32767;
    end
    send(b);
    wait_out();
    chk("latency", lat, 3);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_y%0d_r", k), ya[k], 800);
      chk($sformatf("t1_y%0d_i", k), ya[4 + k], 0);
    end
    chk("t1_tag", tag_out, 77);
    sync();
    b = '0;
    b.xr[1] = 21'd100;
    b.wr[1] = 16'd32767;
    b.tag = 11'd2;
    model(b, 27);
    chk("model_fwd_y1_i", ey[5], -800);
    chk("model_fwd_y3_i", ey[7], 800);
    send(b);
    wait_out();
    chk("t2f_y0_r", ya[0], 800);
    chk("t2f_y1_r", ya[1], 0);
    chk("t2f_y1_i", ya[5], -800);
    chk("t2f_y2_r", ya[2], -800);
    chk("t2f_y3_i", ya[7], 800);
    sync();
    b.inv = 1;
    b.tag = 11'd3;
    send(b);
    wait_out();
    chk("t2i_y0_r", ya[0], 800);
    chk("t2i_y1_i", ya[5], 800);
    chk("t2i_y3_i", ya[7], -800);
    sync();
    b = '0;
    b.xr[0] = 21'd1048575;
    b.tag = 11'd4;
    send(b);
    wait_out();
    chk("t3p_y0_r", ya[0], 8388600);
    for (int k = 0; k < 4; k++) chk($sformatf("t3p_ow20_y%0d_r", k), yb[k], 524287);
`ifdef FFT4_SAT_FLAG_EN
    chk("t3_sat_flag_set", sat_s, 1);
`endif
    sync();
    b.xr[0] = 21'h100000;
    send(b);
    wait_out();
    chk("t3n_y0_r", ya[0], -8388608);
    for (int k = 0; k < 4; k++) chk($sformatf("t3n_ow20_y%0d_r", k), yb[k], -524288);
    sync();
`ifdef FFT4_SAT_FLAG_EN
    @(negedge clk);
    chk("t3_sat_flag_sticky", sat_s, 1);
    sync();
    sat_clr = 1;
    sync();
    sat_clr = 0;
    @(negedge clk);
    chk("t3_sat_flag_clr", sat_s, 0);
    chk("t3_sat_flag_wide", sat_a, 0);
    sync();
`endif
    for (int i = 0; i < 5; i++) begin
      b = '0;
      b.xr[1] = 21'(rx[i]);
      b.wr[1] = 16'(rw[i]);
      b.tag = 11'(10 + i);
      send(b);
      wait_out();
      chk($sformatf("t4_%0d_y0_r", i), ya[0], r0[i]);
      chk($sformatf("t4_%0d_y2_r", i), ya[2], r2[i]);
      sync();
    end
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          b.inv = 1'($urandom);
          b.tag = 11'(100 + i);
          for (int n = 0; n < 4; n++) begin
            b.xr[n] = 21'($urandom);
            b.xi[n] = 21'($urandom);
            b.wr[n] = 16'($urandom);
            b.wi[n] = 16'($urandom);
          end
          send(b);
        end
        done = 1;
      end
      begin
        while (!done) begin
          sync();
          out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    out_ready = 1;
    repeat (10) sync();
    got_tags.delete();
    base = n_acc;
    out_ready = 0;
    fork
      begin
        for (int t = 1; t <= 6; t++) begin
          b = '0;
          b.tag = 11'(t);
          b.xr[0] = 21'(t * 1000);
          b.xi[1] = 21'(-t * 777);
          b.wr[1] = 16'(t * 3000);
          b.wi[1] = 16'(-t * 2500);
          b.inv = 1'(t % 2);
          send(b);
        end
      end
      begin
        repeat (12) @(negedge clk);
        chk("bp_accepted", n_acc - base, 4);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_tag_hold", tag_out, 1);
        sync();
        out_ready = 1;
      end
    join
    repeat (12) sync();
    chk("bp_count", got_tags.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < got_tags.size()) chk($sformatf("bp_order_%0d", i), got_tags[i], i + 1);
    for (int t = 1; t <= 3; t++) begin
      b = '0;
      b.xr[0] = 21'(100 * t);
      b.tag = 11'(20 + t);
      send(b);
    end
    rst = 1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_y0_r", ya[0], 0);
    chk("mid_rst_y1_i", ya[5], 0);
    chk("mid_rst_ow20_y0_r", yb[0], 0);
    chk("mid_rst_tag_out", tag_out, 0);
    sync();
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("post_rst_no_stale", stale, 0);
    sync();
    b = '0;
    b.xr[0] = 21'd100;
    b.tag = 11'd30;
    send(b);
    wait_out();
    chk("post_rst_y0_r", ya[0], 800);
    chk("post_rst_tag", tag_out, 30);
    sync();
    repeat (4) sync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
